// File: rtl/exponent_add_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : exponent_add_pipe
//  Description : Pipelined exponent path for the floating-point multiplier.
//                Adds two biased exponents, removes the bias and classifies
//                the operands and the result (zero / infinity / NaN /
//                overflow / underflow). Produces a saturated biased result
//                exponent plus the signed, unsaturated raw sum for the
//                downstream normalisation stage. Valid/ready handshake on
//                both sides; all stages stall together.
//
//  Parameters  : EXP_W   exponent field width (4..11)
//                BIAS    exponent bias subtracted from the sum
//                STAGES  register stages from input to output (1..4)
//
//  Ports       : clk        clock, rising edge
//                rst        synchronous active-high reset
//                in_valid   operand pair valid
//                in_ready   pair accepted this cycle (pipe advancing)
//                exp_a      biased exponent of operand a  [EXP_W]
//                exp_b      biased exponent of operand b  [EXP_W]
//                out_valid  result valid
//                out_ready  downstream accepts the result
//                exp_out    saturated biased result exponent [EXP_W]
//                exp_raw    signed exp_a + exp_b - BIAS       [EXP_W+2]
//                f_zero     result is zero
//                f_inf      result is infinity / special exponent
//                f_nan      result is NaN (zero times special)
//                f_ovf      finite non-zero operands overflowed
//                f_unf      finite non-zero operands underflowed
//
//  Revision    : 1.0  initial release
// ============================================================================
module exponent_add_pipe #(
    parameter int EXP_W  = 8,
    parameter int BIAS   = 2**(EXP_W-1)-1,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W-1:0]   exp_a,
    input  logic [EXP_W-1:0]   exp_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   exp_out,
    output logic [EXP_W+1:0]   exp_raw,
    output logic               f_zero,
    output logic               f_inf,
    output logic               f_nan,
    output logic               f_ovf,
    output logic               f_unf
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The raw sum needs two extra bits: one for the carry of a+b and one for
    // the sign after the bias is removed. Within the legal EXP_W / BIAS range
    // the value never wraps.
    localparam int                 c_raw_w  = EXP_W + 2;
    // Pipeline payload: exponent, raw sum and five flags.
    localparam int                 c_data_w = EXP_W + c_raw_w + 5;
    localparam logic [EXP_W-1:0]   c_max    = {EXP_W{1'b1}};
    localparam logic [c_raw_w-1:0] c_max_ext = {2'b00, c_max};
    localparam logic [c_raw_w-1:0] c_bias   = c_raw_w'(BIAS);

    // ------------------------------------------------------------------------
    // Stage 1 arithmetic and classification (combinational)
    // ------------------------------------------------------------------------
    logic                 w_a_zero;
    logic                 w_b_zero;
    logic                 w_a_spec;
    logic                 w_b_spec;
    logic [c_raw_w-1:0]   w_raw;
    logic                 w_raw_ovf;
    logic                 w_raw_unf;

    logic [EXP_W-1:0]     w_exp_out;
    logic                 w_nan;
    logic                 w_inf;
    logic                 w_zero;
    logic                 w_ovf;
    logic                 w_unf;
    logic [c_data_w-1:0]  w_data;

    // Subnormals are flushed, so an all-zero field is simply zero; the
    // all-ones field marks infinity or NaN (mantissa decides downstream).
    assign w_a_zero = (exp_a == '0);
    assign w_b_zero = (exp_b == '0);
    assign w_a_spec = (exp_a == c_max);
    assign w_b_spec = (exp_b == c_max);

    assign w_raw = {2'b00, exp_a} + {2'b00, exp_b} - c_bias;

    // Signed range checks on the raw sum. A raw value of exactly MAX would
    // encode the special exponent, so it already counts as overflow.
    assign w_raw_ovf = ($signed(w_raw) >= $signed(c_max_ext));
    assign w_raw_unf = w_raw[c_raw_w-1] || (w_raw == '0);

    // Priority classification. Operand classes dominate the result range
    // checks so that overflow/underflow only ever report finite, non-zero
    // operands. Exactly one of nan/inf/zero can be set.
    always_comb begin
        w_exp_out = '0;
        w_nan     = 1'b0;
        w_inf     = 1'b0;
        w_zero    = 1'b0;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        if ((w_a_zero && w_b_spec) || (w_b_zero && w_a_spec)) begin
            // zero times infinity/NaN
            w_nan     = 1'b1;
            w_exp_out = c_max;
        end else if (w_a_spec || w_b_spec) begin
            w_inf     = 1'b1;
            w_exp_out = c_max;
        end else if (w_a_zero || w_b_zero) begin
            w_zero    = 1'b1;
            w_exp_out = '0;
        end else if (w_raw_ovf) begin
            w_ovf     = 1'b1;
            w_inf     = 1'b1;
            w_exp_out = c_max;
        end else if (w_raw_unf) begin
            w_unf     = 1'b1;
            w_zero    = 1'b1;
            w_exp_out = '0;
        end else begin
            w_exp_out = w_raw[EXP_W-1:0];
        end
    end

    assign w_data = {w_exp_out, w_raw, w_nan, w_inf, w_zero, w_ovf, w_unf};

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    // All stages share one advance enable: the whole pipe moves whenever the
    // output register is empty or being drained. Bubbles therefore travel
    // with the pipe instead of being squeezed out, which keeps the latency
    // fixed at STAGES cycles and the control trivially small.
    logic [STAGES-1:0]    r_valid;
    logic [c_data_w-1:0]  r_data [STAGES];
    logic                 w_adv;

    assign w_adv    = !r_valid[STAGES-1] || out_ready;
    assign in_ready = w_adv;

    // First stage captures the computed result. Data is only loaded on an
    // accept so that bubbles leave the payload registers untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid[0] <= 1'b0;
            r_data[0]  <= '0;
        end else if (w_adv) begin
            r_valid[0] <= in_valid;
            if (in_valid) begin
                r_data[0] <= w_data;
            end
        end
    end

    // Remaining stages just carry the payload forward.
    generate
        for (genvar s = 1; s < STAGES; s++) begin : g_stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[s] <= 1'b0;
                    r_data[s]  <= '0;
                end else if (w_adv) begin
                    r_valid[s] <= r_valid[s-1];
                    if (r_valid[s-1]) begin
                        r_data[s] <= r_data[s-1];
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_valid = r_valid[STAGES-1];
    assign {exp_out, exp_raw, f_nan, f_inf, f_zero, f_ovf, f_unf} = r_data[STAGES-1];

endmodule
`default_nettype wire

// File: doc/exponent_add_pipe.md
Name: exponent_add_pipe

Overview:
Parametrised, pipelined exponent path for the floating-point multiplier datapath. It adds two biased exponents and removes the bias, then classifies the operands and the result: zero, infinity, NaN, overflow and underflow. It presents a saturated result exponent plus the signed raw sum for the downstream normalisation stage. The block replaces the single-cycle combinational exponent adder and adds a valid/ready handshake, configurable exponent width, configurable bias and configurable pipeline depth.

Parameters:
EXP_W, 8, exponent field width in bits (8 = bfloat16/fp32, 5 = fp16); legal range 4..11
BIAS, 2**(EXP_W-1)-1, exponent bias subtracted from the sum
STAGES, 2, register stages from input to output; legal range 1..4

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input operand pair valid
in_ready  output  1  block accepts the pair this cycle
exp_a  input  EXP_W  biased exponent of operand a
exp_b  input  EXP_W  biased exponent of operand b
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
exp_out  output  EXP_W  saturated biased result exponent
exp_raw  output  EXP_W+2  signed exp_a+exp_b-BIAS, unsaturated
f_zero  output  1  result is zero
f_inf  output  1  result is infinity
f_nan  output  1  result is NaN
f_ovf  output  1  finite operands overflowed the exponent range
f_unf  output  1  finite operands underflowed (flushed to zero)

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: all stage valid bits clear, so out_valid=0. All data and flag registers are 0. in_ready=1 in the first cycle after reset.
- rst asserted mid-operation discards every in-flight pair on the next edge. No output fires for a discarded pair.
- Handshake: the pipe advances when adv = !out_valid || out_ready, and in_ready = adv.
  - A transfer occurs on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
  - While out_valid && !out_ready, every stage and every output holds stable.
  - Bubbles (invalid stages) advance with the pipe and are not collapsed.
- Latency: exactly STAGES cycles from input accept to out_valid when never stalled. Throughput is one pair per cycle.
- Arithmetic:
  - raw = zero-ext(exp_a) + zero-ext(exp_b) - BIAS, computed signed in EXP_W+2 bits; it never wraps across the legal range.
  - MAX = 2**EXP_W-1 (the all-ones value).
  - Compute in stage 1 and register through the remaining stages. Classification may be split across stages but results must match.
- Operand classes:
  - zero when exp==0 (subnormals are flushed to zero).
  - special when exp==MAX.
- Flag priority (exactly one of f_nan, f_inf, f_zero may be set; f_ovf and f_unf are set only for finite non-zero operands):
  1. Either operand zero and the other special: f_nan=1, exp_out=MAX.
  2. Either operand special: f_inf=1, exp_out=MAX. The NaN-vs-infinity distinction needs mantissas and is resolved downstream; f_inf here means "special exponent".
  3. Either operand zero: f_zero=1, exp_out=0.
  4. raw >= MAX: f_ovf=1, f_inf=1, exp_out=MAX.
  5. raw <= 0: f_unf=1, f_zero=1, exp_out=0.
  6. Otherwise: exp_out=raw[EXP_W-1:0] with all flags 0.
- exp_raw always carries raw, regardless of class. Downstream applies the mantissa-normalisation +1 and re-checks raw+1 == MAX.
- Simultaneous input accept and output pop in the same cycle is legal and loses no data.
- in_valid dropping while in_ready=0 is permitted. Data is sampled only on an accept edge.

Test Plan:
- EXP_W=8, STAGES=2, exp_a=127, exp_b=127, out_ready=1 -> after 2 cycles out_valid=1, exp_out=127, exp_raw=127, all flags 0.
- exp_a=200, exp_b=200 -> exp_raw=273, f_ovf=1, f_inf=1, exp_out=255. Then exp_a=10, exp_b=20 -> exp_raw=-97, f_unf=1, f_zero=1, exp_out=0.
- Specials: (0,255) -> f_nan=1, exp_out=255; (255,1) -> f_inf=1, f_ovf=0; (0,130) -> f_zero=1, exp_out=0. Boundaries: (127,127+127) -> raw=254, normal; (128,254) -> raw=255, f_ovf=1.
- Streaming with back-pressure: 8 back-to-back pairs while out_ready is low for cycles 3-5 -> in_ready=0 on those cycles, outputs held stable, all 8 results emerge in order with none lost or duplicated.
- Reset mid-flight: 2 pairs in the pipe, rst=1 for 1 cycle -> out_valid=0 on the next cycle, the discarded pairs never appear, and a fresh pair after reset has latency STAGES.
- Re-parametrise EXP_W=5, BIAS=15, STAGES=1: (15,15) -> exp_out=15, latency 1; (20,30) -> raw=35, f_ovf=1, exp_out=31.
